// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle MIPS control unit. This
//            covers FSM states, opcode/funct values, datapath mux codes and
//            the decoded instruction-class record.
//            Build macro MC_CTRL_MDU_EN enables the multiply/divide group
//            (mult, multu, div, divu, mfhi, mflo, mthi, mtlo).
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // The multiply/divide group is optional. When it is left out, those
    // encodings fall through to illegal and S_MDU is never entered.
`ifdef MC_CTRL_MDU_EN
    localparam logic c_MDU_EN = 1'b1;
`else
    localparam logic c_MDU_EN = 1'b0;
`endif

    // FSM state encodings
    localparam logic [2:0] c_S_FETCH  = 3'd0;
    localparam logic [2:0] c_S_DECODE = 3'd1;
    localparam logic [2:0] c_S_EXEC   = 3'd2;
    localparam logic [2:0] c_S_MEM    = 3'd3;
    localparam logic [2:0] c_S_WB     = 3'd4;
    localparam logic [2:0] c_S_MDU    = 3'd5;

    // Primary opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_MFHI  = 6'h10;
    localparam logic [5:0] c_FN_MTHI  = 6'h11;
    localparam logic [5:0] c_FN_MFLO  = 6'h12;
    localparam logic [5:0] c_FN_MTLO  = 6'h13;
    localparam logic [5:0] c_FN_MULT  = 6'h18;
    localparam logic [5:0] c_FN_MULTU = 6'h19;
    localparam logic [5:0] c_FN_DIV   = 6'h1A;
    localparam logic [5:0] c_FN_DIVU  = 6'h1B;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;

    // Next-PC select
    localparam logic [1:0] c_NPC_PC4  = 2'd0;
    localparam logic [1:0] c_NPC_BR   = 2'd1;
    localparam logic [1:0] c_NPC_JIMM = 2'd2;
    localparam logic [1:0] c_NPC_JREG = 2'd3;

    // Destination register select
    localparam logic [1:0] c_RDST_RT  = 2'd0;
    localparam logic [1:0] c_RDST_RD  = 2'd1;
    localparam logic [1:0] c_RDST_RA  = 2'd2;

    // Write-back source select
    localparam logic [1:0] c_M2R_MEM  = 2'd0;
    localparam logic [1:0] c_M2R_ALU  = 2'd1;
    localparam logic [1:0] c_M2R_LUI  = 2'd2;
    localparam logic [1:0] c_M2R_PC   = 2'd3;

    // ALU operation
    localparam logic [1:0] c_ALU_ADD  = 2'd0;
    localparam logic [1:0] c_ALU_SUB  = 2'd1;
    localparam logic [1:0] c_ALU_OR   = 2'd2;

    // Immediate extension
    localparam logic [1:0] c_EXT_ZERO = 2'd0;
    localparam logic [1:0] c_EXT_SIGN = 2'd1;
    localparam logic [1:0] c_EXT_UP   = 2'd2;

    // One-hot instruction class
    typedef struct packed {
        logic rcalc;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic mdu_long;
        logic mdu_move;
        logic illegal;
    } instr_class_t;

    // Class plus the few qualifiers the FSM needs within a class
    typedef struct packed {
        instr_class_t cls;
        logic         sub;   // rcalc: subtract rather than add
        logic         div;   // mdu_long: divide latency rather than multiply
        logic         mf;    // mdu_move: mfhi/mflo writes the regfile
    } decode_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_if
// Purpose  : Control bus between the multi-cycle controller (master) and
//            the IR/regfile/ALU/memory datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    // Datapath status toward the controller
    logic [31:0]      instr;
    logic             mem_ready;
    logic             zero;

    // Controls toward the datapath
    logic             pc_write;
    logic [1:0]       npc_sel;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             reg_write;
    logic [1:0]       regdst;
    logic [1:0]       memtoreg;
    logic             alusrc;
    logic [1:0]       aluctrl;
    logic [1:0]       extop;
    logic             mdu_start;
    logic             instr_done;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  instr, mem_ready, zero,
        output pc_write, npc_sel, ir_write, mem_read, mem_write, iord,
               reg_write, regdst, memtoreg, alusrc, aluctrl, extop,
               mdu_start, instr_done, illegal, state, instr_count
    );

    modport slave (
        output instr, mem_ready, zero,
        input  pc_write, npc_sel, ir_write, mem_read, mem_write, iord,
               reg_write, regdst, memtoreg, alusrc, aluctrl, extop,
               mdu_start, instr_done, illegal, state, instr_count
    );

endinterface
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_decode
// Purpose  : Combinational opcode/funct classifier producing a one-hot
//            instruction class for the controller FSM.
//            The multiply/divide group is recognised only when built with
//            MC_CTRL_MDU_EN; otherwise it decodes as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  wire [5:0] i_op,
    input  wire [5:0] i_funct,
    output decode_t   o_dec
);

    logic w_mdu_long;
    logic w_mdu_mf;
    logic w_mdu_mt;

    assign w_mdu_long = c_MDU_EN && (i_funct inside {c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU});
    assign w_mdu_mf   = c_MDU_EN && (i_funct inside {c_FN_MFHI, c_FN_MFLO});
    assign w_mdu_mt   = c_MDU_EN && (i_funct inside {c_FN_MTHI, c_FN_MTLO});

    // Map opcode/funct onto exactly one class bit
    always_comb begin
        o_dec = '0;
        case (i_op)
            c_OP_RTYPE: begin
                if (i_funct == c_FN_ADDU) begin
                    o_dec.cls.rcalc = 1'b1;
                end else if (i_funct == c_FN_SUBU) begin
                    o_dec.cls.rcalc = 1'b1;
                    o_dec.sub       = 1'b1;
                end else if (i_funct == c_FN_JR) begin
                    o_dec.cls.jr = 1'b1;
                end else if (w_mdu_long) begin
                    o_dec.cls.mdu_long = 1'b1;
                    o_dec.div          = (i_funct inside {c_FN_DIV, c_FN_DIVU});
                end else if (w_mdu_mf || w_mdu_mt) begin
                    o_dec.cls.mdu_move = 1'b1;
                    o_dec.mf           = w_mdu_mf;
                end else begin
                    o_dec.cls.illegal = 1'b1;
                end
            end
            c_OP_J:   o_dec.cls.j   = 1'b1;
            c_OP_JAL: o_dec.cls.jal = 1'b1;
            c_OP_BEQ: o_dec.cls.beq = 1'b1;
            c_OP_ORI: o_dec.cls.ori = 1'b1;
            c_OP_LUI: o_dec.cls.lui = 1'b1;
            c_OP_LW:  o_dec.cls.lw  = 1'b1;
            c_OP_SW:  o_dec.cls.sw  = 1'b1;
            default:  o_dec.cls.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle MIPS control unit. FSM sequences FETCH, DECODE,
//            EXEC, MEM, WB (and MDU) per instruction, with a mem_ready
//            handshake and a retired-instruction counter. Controls are pure
//            decodes of state, instr, zero and mem_ready. Only the state and
//            counters are flops.
//            Build macro MC_CTRL_MDU_EN enables the S_MDU wait state and
//            the mdu_start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 32
)(
    input  wire       clk,
    input  wire       reset,
    mc_ctrl_if.master bus
);

    // The counter must hold the largest LAT-1 value
    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_MDU_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;
    localparam logic [c_MDU_W-1:0] c_MUL_LOAD = c_MDU_W'(MUL_LAT - 1);
    localparam logic [c_MDU_W-1:0] c_DIV_LOAD = c_MDU_W'(DIV_LAT - 1);

    logic [2:0]         r_state;
    logic [c_MDU_W-1:0] r_mdu_cnt;
    logic [CNT_W-1:0]   r_instr_count;

    logic [2:0]         w_state_nxt;
    logic               w_cnt_load;
    logic [c_MDU_W-1:0] w_cnt_val;
    decode_t            w_dec;

    logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_iord;
    logic       w_reg_write, w_alusrc, w_mdu_start, w_done, w_illegal;
    logic [1:0] w_npc_sel, w_regdst, w_memtoreg, w_aluctrl, w_extop;

    // Only opcode and funct drive classification
    wire w_unused_instr = ^bus.instr[25:6];

    mc_ctrl_decode u_decode (
        .i_op    (bus.instr[31:26]),
        .i_funct (bus.instr[5:0]),
        .o_dec   (w_dec)
    );

    // Per-state control decode and next-state selection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = c_MUL_LOAD;
        w_pc_write  = 1'b0;
        w_npc_sel   = c_NPC_PC4;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_iord      = 1'b0;
        w_reg_write = 1'b0;
        w_regdst    = c_RDST_RT;
        w_memtoreg  = c_M2R_MEM;
        w_alusrc    = 1'b0;
        w_aluctrl   = c_ALU_ADD;
        w_extop     = c_EXT_ZERO;
        w_mdu_start = 1'b0;
        w_illegal   = 1'b0;

        case (r_state)
            c_S_FETCH: begin
                w_mem_read = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    w_state_nxt = c_S_DECODE;
                end
            end
            c_S_DECODE: begin
                if (w_dec.cls.j) begin
                    w_pc_write  = 1'b1;
                    w_npc_sel   = c_NPC_JIMM;
                    w_state_nxt = c_S_FETCH;
                end else if (w_dec.cls.jal) begin
                    w_pc_write  = 1'b1;
                    w_npc_sel   = c_NPC_JIMM;
                    w_reg_write = 1'b1;
                    w_regdst    = c_RDST_RA;
                    w_memtoreg  = c_M2R_PC;
                    w_state_nxt = c_S_FETCH;
                end else if (w_dec.cls.jr) begin
                    w_pc_write  = 1'b1;
                    w_npc_sel   = c_NPC_JREG;
                    w_state_nxt = c_S_FETCH;
                end else if (w_dec.cls.illegal) begin
                    w_illegal   = 1'b1;
                    w_state_nxt = c_S_FETCH;
                end else begin
                    w_state_nxt = c_S_EXEC;
                end
            end
            c_S_EXEC: begin
                if (w_dec.cls.rcalc) begin
                    w_aluctrl   = w_dec.sub ? c_ALU_SUB : c_ALU_ADD;
                    w_state_nxt = c_S_WB;
                end else if (w_dec.cls.ori) begin
                    w_alusrc    = 1'b1;
                    w_aluctrl   = c_ALU_OR;
                    w_extop     = c_EXT_ZERO;
                    w_state_nxt = c_S_WB;
                end else if (w_dec.cls.lui) begin
                    w_alusrc    = 1'b1;
                    w_extop     = c_EXT_UP;
                    w_state_nxt = c_S_WB;
                end else if (w_dec.cls.lw || w_dec.cls.sw) begin
                    w_alusrc    = 1'b1;
                    w_extop     = c_EXT_SIGN;
                    w_state_nxt = c_S_MEM;
                end else if (w_dec.cls.beq) begin
                    w_aluctrl   = c_ALU_SUB;
                    w_pc_write  = bus.zero;
                    w_npc_sel   = c_NPC_BR;
                    w_state_nxt = c_S_FETCH;
                end else if (w_dec.cls.mdu_long) begin
                    w_mdu_start = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = w_dec.div ? c_DIV_LOAD : c_MUL_LOAD;
                    w_state_nxt = c_S_MDU;
                end else if (w_dec.cls.mdu_move && w_dec.mf) begin
                    w_state_nxt = c_S_WB;
                end else begin
                    // mthi/mtlo: the MDU latches rs directly this cycle
                    w_state_nxt = c_S_FETCH;
                end
            end
            c_S_MEM: begin
                w_iord = 1'b1;
                if (w_dec.cls.lw) begin
                    w_mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        w_state_nxt = c_S_WB;
                    end
                end else begin
                    w_mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        w_state_nxt = c_S_FETCH;
                    end
                end
            end
            c_S_WB: begin
                w_reg_write = 1'b1;
                w_regdst    = (w_dec.cls.rcalc || w_dec.cls.mdu_move) ? c_RDST_RD : c_RDST_RT;
                if (w_dec.cls.lw) begin
                    w_memtoreg = c_M2R_MEM;
                end else if (w_dec.cls.lui) begin
                    w_memtoreg = c_M2R_LUI;
                end else begin
                    w_memtoreg = c_M2R_ALU;
                end
                w_state_nxt = c_S_FETCH;
            end
            c_S_MDU: begin
                if (r_mdu_cnt == '0) begin
                    w_state_nxt = c_S_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_S_FETCH;
            end
        endcase

        // Every path back to FETCH retires exactly one instruction
        w_done = (r_state != c_S_FETCH) && (w_state_nxt == c_S_FETCH);

        // Reset suppresses every enable and pulse in the cycle it is seen
        if (reset) begin
            w_pc_write  = 1'b0;
            w_npc_sel   = c_NPC_PC4;
            w_ir_write  = 1'b0;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_iord      = 1'b0;
            w_reg_write = 1'b0;
            w_regdst    = c_RDST_RT;
            w_memtoreg  = c_M2R_MEM;
            w_alusrc    = 1'b0;
            w_aluctrl   = c_ALU_ADD;
            w_extop     = c_EXT_ZERO;
            w_mdu_start = 1'b0;
            w_illegal   = 1'b0;
            w_done      = 1'b0;
        end
    end

    // State, MDU wait counter and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_S_FETCH;
            r_mdu_cnt     <= '0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_load) begin
                r_mdu_cnt <= w_cnt_val;
            end else if ((r_state == c_S_MDU) && (r_mdu_cnt != '0)) begin
                r_mdu_cnt <= r_mdu_cnt - c_MDU_W'(1);
            end
            if (w_done) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.npc_sel     = w_npc_sel;
    assign bus.ir_write    = w_ir_write;
    assign bus.mem_read    = w_mem_read;
    assign bus.mem_write   = w_mem_write;
    assign bus.iord        = w_iord;
    assign bus.reg_write   = w_reg_write;
    assign bus.regdst      = w_regdst;
    assign bus.memtoreg    = w_memtoreg;
    assign bus.alusrc      = w_alusrc;
    assign bus.aluctrl     = w_aluctrl;
    assign bus.extop       = w_extop;
    assign bus.mdu_start   = c_MDU_EN & w_mdu_start;
    assign bus.instr_done  = w_done;
    assign bus.illegal     = w_illegal;
    assign bus.state       = r_state;
    assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Directed self-checking bench for mc_ctrl. Each cycle compares
//            the state and the packed control vector against hand-computed
//            values. Instruction counts are checked after every retirement.
//            The MC_CTRL_MDU_EN build macro selects the mult expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    localparam int S_F = 0;
    localparam int S_D = 1;
    localparam int S_E = 2;
    localparam int S_M = 3;
    localparam int S_W = 4;
    localparam int S_U = 5;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mc_ctrl_if #(.CNT_W(32)) bus ();

    mc_ctrl #(
        .MUL_LAT (5),
        .DIV_LAT (10),
        .CNT_W   (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {pcw, npc, irw, mr, mw, iord, rw, regdst, memtoreg, alusrc, aluctrl, extop, mdu_start, done, illegal}
    wire [19:0] ctl = {bus.pc_write, bus.npc_sel, bus.ir_write, bus.mem_read, bus.mem_write,
                       bus.iord, bus.reg_write, bus.regdst, bus.memtoreg, bus.alusrc,
                       bus.aluctrl, bus.extop, bus.mdu_start, bus.instr_done, bus.illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] E(input int pcw, input int npc, input int irw, input int mr,
                                      input int mw, input int iord, input int rw, input int rd,
                                      input int m2r, input int asrc, input int alu, input int ext,
                                      input int mdus, input int done, input int ill);
        return {1'(pcw), 2'(npc), 1'(irw), 1'(mr), 1'(mw), 1'(iord), 1'(rw), 2'(rd),
                2'(m2r), 1'(asrc), 2'(alu), 2'(ext), 1'(mdus), 1'(done), 1'(ill)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge
    task automatic step(input string tag, input int st, input logic [19:0] ex);
        #2;
        check({tag, ".state"}, 32'(st), {29'b0, bus.state});
        check({tag, ".ctl"}, {12'b0, ex}, {12'b0, ctl});
        @(posedge clk);
        #1;
    endtask

    logic [19:0] f_rdy;
    logic [19:0] nil;

    initial begin
        f_rdy = E(1,0,1,1,0,0,0,0,0,0,0,0,0,0,0);
        nil   = '0;
        reset = 1'b1;
        bus.instr     = '0;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with mem_ready high: no enables
        bus.mem_ready = 1'b1;
        bus.instr     = 32'h0022_1821;             // addu $3,$1,$2
        step("rst", S_F, nil);
        check("rst.cnt", bus.instr_count, 32'd0);
        reset = 1'b0;

        step("addu.F", S_F, f_rdy);
        step("addu.D", S_D, nil);
        step("addu.E", S_E, nil);
        step("addu.W", S_W, E(0,0,0,0,0,0,1,1,1,0,0,0,0,1,0));
        check("addu.cnt", bus.instr_count, 32'd1);

        // lw with three stalled memory cycles
        bus.instr = 32'h8C22_0004;
        step("lw.F", S_F, f_rdy);
        step("lw.D", S_D, nil);
        step("lw.E", S_E, E(0,0,0,0,0,0,0,0,0,1,0,1,0,0,0));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw.Mwait", S_M, E(0,0,0,1,0,1,0,0,0,0,0,0,0,0,0));
        bus.mem_ready = 1'b1;
        step("lw.M", S_M, E(0,0,0,1,0,1,0,0,0,0,0,0,0,0,0));
        step("lw.W", S_W, E(0,0,0,0,0,0,1,0,0,0,0,0,0,1,0));
        check("lw.cnt", bus.instr_count, 32'd2);

        // beq taken then not taken
        bus.instr = 32'h1022_0003;
        bus.zero  = 1'b1;
        step("beq1.F", S_F, f_rdy);
        step("beq1.D", S_D, nil);
        step("beq1.E", S_E, E(1,1,0,0,0,0,0,0,0,0,1,0,0,1,0));
        check("beq1.cnt", bus.instr_count, 32'd3);
        bus.zero = 1'b0;
        step("beq0.F", S_F, f_rdy);
        step("beq0.D", S_D, nil);
        step("beq0.E", S_E, E(0,1,0,0,0,0,0,0,0,0,1,0,0,1,0));
        check("beq0.cnt", bus.instr_count, 32'd4);

        // ori
        bus.instr = 32'h3422_0005;
        step("ori.F", S_F, f_rdy);
        step("ori.D", S_D, nil);
        step("ori.E", S_E, E(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0));
        step("ori.W", S_W, E(0,0,0,0,0,0,1,0,1,0,0,0,0,1,0));
        check("ori.cnt", bus.instr_count, 32'd5);

        // lui
        bus.instr = 32'h3C01_1234;
        step("lui.F", S_F, f_rdy);
        step("lui.D", S_D, nil);
        step("lui.E", S_E, E(0,0,0,0,0,0,0,0,0,1,0,2,0,0,0));
        step("lui.W", S_W, E(0,0,0,0,0,0,1,0,2,0,0,0,0,1,0));
        check("lui.cnt", bus.instr_count, 32'd6);

        // sw with one stalled fetch cycle
        bus.instr     = 32'hAC22_0008;
        bus.mem_ready = 1'b0;
        step("sw.Fwait", S_F, E(0,0,0,1,0,0,0,0,0,0,0,0,0,0,0));
        bus.mem_ready = 1'b1;
        step("sw.F", S_F, f_rdy);
        step("sw.D", S_D, nil);
        step("sw.E", S_E, E(0,0,0,0,0,0,0,0,0,1,0,1,0,0,0));
        step("sw.M", S_M, E(0,0,0,0,1,1,0,0,0,0,0,0,0,1,0));
        check("sw.cnt", bus.instr_count, 32'd7);

        // j, jr, jal, illegal
        bus.instr = 32'h0800_0010;
        step("j.F", S_F, f_rdy);
        step("j.D", S_D, E(1,2,0,0,0,0,0,0,0,0,0,0,0,1,0));
        check("j.cnt", bus.instr_count, 32'd8);
        bus.instr = 32'h03E0_0008;
        step("jr.F", S_F, f_rdy);
        step("jr.D", S_D, E(1,3,0,0,0,0,0,0,0,0,0,0,0,1,0));
        check("jr.cnt", bus.instr_count, 32'd9);
        bus.instr = 32'h0C00_0010;
        step("jal.F", S_F, f_rdy);
        step("jal.D", S_D, E(1,2,0,0,0,0,1,2,3,0,0,0,0,1,0));
        check("jal.cnt", bus.instr_count, 32'd10);
        bus.instr = 32'hFC00_0000;
        step("ill.F", S_F, f_rdy);
        step("ill.D", S_D, E(0,0,0,0,0,0,0,0,0,0,0,0,0,1,1));
        check("ill.cnt", bus.instr_count, 32'd11);

        // subu
        bus.instr = 32'h0022_1823;
        step("subu.F", S_F, f_rdy);
        step("subu.D", S_D, nil);
        step("subu.E", S_E, E(0,0,0,0,0,0,0,0,0,0,1,0,0,0,0));
        step("subu.W", S_W, E(0,0,0,0,0,0,1,1,1,0,0,0,0,1,0));
        check("subu.cnt", bus.instr_count, 32'd12);

        // mult: five-cycle wait with the MDU, illegal without it
        bus.instr = 32'h0022_0018;
        step("mult.F", S_F, f_rdy);
`ifdef MC_CTRL_MDU_EN
        step("mult.D", S_D, nil);
        step("mult.E", S_E, E(0,0,0,0,0,0,0,0,0,0,0,0,1,0,0));
        for (int i = 0; i < 4; i++) step("mult.U", S_U, nil);
        step("mult.Ulast", S_U, E(0,0,0,0,0,0,0,0,0,0,0,0,0,1,0));
`else
        step("mult.D", S_D, E(0,0,0,0,0,0,0,0,0,0,0,0,0,1,1));
`endif
        check("mult.cnt", bus.instr_count, 32'd13);

        // Reset arriving during the stalled MEM cycle of sw
        bus.instr = 32'hAC22_0008;
        step("swr.F", S_F, f_rdy);
        step("swr.D", S_D, nil);
        step("swr.E", S_E, E(0,0,0,0,0,0,0,0,0,1,0,1,0,0,0));
        bus.mem_ready = 1'b0;
        step("swr.M", S_M, E(0,0,0,0,1,1,0,0,0,0,0,0,0,0,0));
        reset = 1'b1;
        step("swr.rst", S_M, nil);
        check("swr.cnt", bus.instr_count, 32'd0);
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        step("swr.F2", S_F, f_rdy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
